// File: rtl/reset_sequencer.sv
// Staged reset release: waits for a filtered PLL lock, then releases per-stage
// active-low resets in ascending order; lock loss or a soft request re-asserts all.
module reset_sequencer #(
  parameter int NUM_STAGES    = 4,
  parameter int STAGE_DELAY   = 256,
  parameter int LOCK_FILTER   = 16,
  parameter int SOFT_RST_HOLD = 32
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  PLL_LOCK,
  input  logic                  Soft_Reset_Req,
  output logic [NUM_STAGES-1:0] Stage_Reset_N,
  output logic                  Sequence_Done,
  output logic                  Busy,
  output logic [7:0]            Lock_Lost_Count
);

  localparam int FW = (LOCK_FILTER   > 1) ? $clog2(LOCK_FILTER)   : 1;
  localparam int DW = (STAGE_DELAY   > 1) ? $clog2(STAGE_DELAY)   : 1;
  localparam int HW = (SOFT_RST_HOLD > 1) ? $clog2(SOFT_RST_HOLD) : 1;
  localparam int IW = (NUM_STAGES    > 1) ? $clog2(NUM_STAGES)    : 1;

  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [DW-1:0] DLY_LAST  = DW'(STAGE_DELAY - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(SOFT_RST_HOLD - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  lock_meta_q, lock_s_q;
  logic [FW-1:0]         filt_q, filt_d;
  logic [DW-1:0]         dly_q, dly_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [7:0]            cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= PLL_LOCK;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= WAIT_LOCK;
      filt_q  <= '0;
      dly_q   <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      dly_q   <= dly_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    dly_d   = dly_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = done_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      WAIT_LOCK: begin
        if (!lock_s_q) begin
          filt_d = '0;
        end else if (filt_q == FILT_LAST) begin
          filt_d  = '0;
          idx_d   = '0;
          dly_d   = '0;
          state_d = RELEASE;
        end else begin
          filt_d = filt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (dly_q == DLY_LAST) begin
          dly_d          = '0;
          stage_d[idx_q] = 1'b1;
          // Index is not advanced past the last stage so it never wraps.
          if (idx_q == IDX_LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = RUN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      RUN: begin
        if (Soft_Reset_Req) begin
          stage_d = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          hold_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          idx_d   = '0;
          dly_d   = '0;
          state_d = RELEASE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    // Lock loss overrides everything decided above, including a soft request.
    if (state_q != WAIT_LOCK && !lock_s_q) begin
      state_d = WAIT_LOCK;
      filt_d  = '0;
      stage_d = '0;
      done_d  = 1'b0;
      busy_d  = 1'b1;
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end
  end

  assign Stage_Reset_N   = stage_q;
  assign Sequence_Done   = done_q;
  assign Busy            = busy_q;
  assign Lock_Lost_Count = cnt_q;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged reset release controller sitting between the clock/reset generation block and the digitizer subsystems. It watches the PLL lock indication and releases a set of per-subsystem active-low resets one after another with a fixed spacing. It re-asserts all of them on PLL lock loss or on a software reset request, and keeps a saturating count of lock-loss events for diagnostics.

## Interface
- NUM_STAGES, 4, number of staged reset outputs (1..8); bit 0 is released first.
- STAGE_DELAY, 256, clock cycles between consecutive stage releases (≥2).
- LOCK_FILTER, 16, consecutive synchronized-lock-high cycles required before sequencing starts (≥1).
- SOFT_RST_HOLD, 32, cycles all stages are held in reset after a soft request (≥1).

Ports:
- CLK  in  1  main fabric clock; single clock domain.
- nRST  in  1  asynchronous, active-low reset.
- PLL_LOCK  in  1  PLL lock, asynchronous to CLK; internally 2-flop synchronized (lock_s).
- Soft_Reset_Req  in  1  single-cycle request pulse; ignored outside RUN.
- Stage_Reset_N  out  NUM_STAGES  per-stage active-low reset, registered.
- Sequence_Done  out  1  high when all stages are released, registered.
- Busy  out  1  high in every state except RUN, registered.
- Lock_Lost_Count  out  8  saturating lock-loss event counter.

## Operation
- Reset (nRST=0, asynchronous):
  - Outputs: Stage_Reset_N=0, Sequence_Done=0, Busy=1, Lock_Lost_Count=0.
  - State WAIT_LOCK; synchronizer flops, filter, delay and stage-index counters all 0.
- FSM states: WAIT_LOCK, RELEASE, RUN, HOLD.
- WAIT_LOCK:
  - Filter counter increments on each edge with lock_s=1 and clears on lock_s=0.
  - When it reaches LOCK_FILTER: go to RELEASE with stage index 0 and delay counter 0.
- RELEASE:
  - Delay counter counts 0..STAGE_DELAY-1.
  - On the terminal count, set Stage_Reset_N[index] to 1, increment index and clear the delay counter.
  - On the edge that releases the last stage: set Sequence_Done=1 and Busy=0, and go to RUN.
- RUN:
  - Soft_Reset_Req=1: Stage_Reset_N=0 and Sequence_Done=0 on the next edge, go to HOLD, clear the hold counter.
- HOLD:
  - Hold counter counts SOFT_RST_HOLD cycles, then go to RELEASE (index 0, delay 0).
- Lock loss (lock_s=0) in RELEASE, RUN or HOLD:
  - On the next edge: Stage_Reset_N=0, Sequence_Done=0, Busy=1.
  - Lock_Lost_Count increments, saturating at 255; go to WAIT_LOCK.
  - lock_s=0 while already in WAIT_LOCK is not counted.
- Priority: lock loss beats Soft_Reset_Req in the same cycle; that event counts once and goes to WAIT_LOCK.
- Soft_Reset_Req in WAIT_LOCK, RELEASE or HOLD is dropped, not queued.
- Release order is strictly ascending. A released stage stays released until a global re-assert; there is no partial re-assert.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit. No wrap-around is reachable other than the saturating Lock_Lost_Count.

## Timing
- PLL_LOCK to lock_s latency: 2 edges.
- With PLL_LOCK high at nRST deassert, stage k releases on edge 2+LOCK_FILTER+(k+1)*STAGE_DELAY.
  - Defaults: stage0 at edge 274, stage3 and Sequence_Done at edge 1042.
- PLL_LOCK falling to Stage_Reset_N low: 3 edges (2 synchronizer + 1 register).
- Lock_Lost_Count updates on the same edge as the re-assert.
- Soft_Reset_Req sampled high on edge E: stages low at E+1; stage0 released at E+1+SOFT_RST_HOLD+STAGE_DELAY.
- Busy and Sequence_Done are exact complements in every cycle after reset.
- nRST assertion mid-sequence clears all outputs immediately, asynchronously, with no clock required.

## Test plan
- Power-up, defaults, PLL_LOCK=1 throughout -> stage0..3 release at edges 274/530/786/1042; Sequence_Done and Busy=0 at edge 1042.
- Lock glitch: PLL_LOCK low for 1 cycle at edge 10 during WAIT_LOCK -> filter restarts; stage0 release shifts later accordingly; Lock_Lost_Count stays 0.
- Lock loss in RUN: drop PLL_LOCK -> all stages 0 three edges later; count=1; full re-sequence after lock returns.
- Soft reset in RUN at edge E -> stages 0 at E+1; stage0 released at E+289; Soft_Reset_Req pulsed during RELEASE is ignored.
- Soft request and lock loss in the same cycle -> WAIT_LOCK; count increments by exactly 1; no HOLD visit.
- 300 lock-loss events -> Lock_Lost_Count saturates at 255; nRST pulse mid-RELEASE -> all outputs return to reset values immediately.
